// File: rtl/bus_arbiter.sv
// Round-robin arbiter for four bus masters with registered active-low grants and owner index.
// Latency: grant moves on the first edge after the owner releases its request (1 cycle, no comb req->grant path).
// Backpressure: a master holds the bus until it releases; with BUS_ARB_TIMEOUT_EN a contended hold is preempted after TIMEOUT_CYCLES.
module bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic       m0_req_,
    input  logic       m1_req_,
    input  logic       m2_req_,
    input  logic       m3_req_,
    output logic       m0_grnt_,
    output logic       m1_grnt_,
    output logic       m2_grnt_,
    output logic       m3_grnt_,
    output logic [1:0] owner,
    output logic       bus_busy
);

    typedef enum logic [1:0] {OWN0, OWN1, OWN2, OWN3} own_t;

    // Reject configurations where the hold counter cannot represent the timeout.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535 || CNT_W < 2 || CNT_W > 30 ||
        (1 << CNT_W) <= TIMEOUT_CYCLES) begin : g_bad_cfg
        $error("bus_arbiter: illegal TIMEOUT_CYCLES/CNT_W combination");
    end

    own_t       state;
    logic [3:0] grnt;
    logic [1:0] cur;
    logic [3:0] req;
    logic [3:0] others;
    logic [1:0] scan_idx;
    logic       scan_hit;
    logic       preempt;
    logic       rotate;
    logic [1:0] nxt_owner;

    // Requests as active-high, indexed by master number.
    assign req    = ~{m3_req_, m2_req_, m1_req_, m0_req_};
    assign cur    = state;
    assign others = req & ~(4'b0001 << cur);

    // First requester after the current owner in rotation order (owner+1, +2, +3).
    always_comb begin
        scan_idx = cur;
        scan_hit = 1'b0;
        for (int i = 1; i < 4; i++) begin
            if (!scan_hit && others[cur + 2'(i)]) begin
                scan_idx = cur + 2'(i);
                scan_hit = 1'b1;
            end
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt;

    // Force a handoff once the owner has held a contended bus for TIMEOUT_CYCLES edges.
    assign preempt = req[cur] && (others != 4'b0000) &&
                     (hold_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count contended hold cycles; clear on handoff or when nobody else wants the bus.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            hold_cnt <= '0;
        end else if (nxt_owner != cur || others == 4'b0000) begin
            hold_cnt <= '0;
        end else if (req[cur] && hold_cnt != CNT_W'(TIMEOUT_CYCLES)) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
        end
    end
`else
    assign preempt = 1'b0;
`endif

    // Rotate on release (or preemption) only if someone else is waiting; otherwise park.
    assign rotate    = ~req[cur] | preempt;
    assign nxt_owner = (rotate && scan_hit) ? scan_idx : cur;

    // Owner state and its one-hot-low grant decode, both registered together.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state <= OWN0;
            grnt  <= 4'b1110;
        end else begin
            state <= own_t'(nxt_owner);
            grnt  <= ~(4'b0001 << nxt_owner);
        end
    end

    assign {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_} = grnt;
    assign owner    = cur;
    assign bus_busy = req[cur];

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: reference model pushes expected outputs per edge.
// Latency: expectations are sampled 1 time unit after each rising edge (or async reset).
// Backpressure: none; stimulus runs freely, checker pops whenever an expectation is queued.
module tb_bus_arbiter;

    localparam int TO = 8;

    logic       clk    = 1'b0;
    logic       reset_ = 1'b0;
    logic [3:0] rq     = 4'hF;   // bit i drives mi_req_ (active low)
    logic       m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
    logic [1:0] owner;
    logic       bus_busy;

    always #5 clk = ~clk;

    bus_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
        .clk      (clk),
        .reset_   (reset_),
        .m0_req_  (rq[0]),
        .m1_req_  (rq[1]),
        .m2_req_  (rq[2]),
        .m3_req_  (rq[3]),
        .m0_grnt_ (m0_grnt_),
        .m1_grnt_ (m1_grnt_),
        .m2_grnt_ (m2_grnt_),
        .m3_grnt_ (m3_grnt_),
        .owner    (owner),
        .bus_busy (bus_busy)
    );

    typedef struct {
        logic [1:0] owner;
        logic [3:0] grnt;
        logic       busy;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: current owner and number of contended edges it has survived.
    int m_owner = 0;
    int m_held  = 0;

    function automatic int next_in_rotation(int o, logic [3:0] want);
        for (int k = 1; k < 4; k++) begin
            if (want[(o + k) % 4]) return (o + k) % 4;
        end
        return o;
    endfunction

    task automatic push_expect();
        exp_t e;
        e.owner = 2'(m_owner);
        e.grnt  = 4'hF;
        e.grnt[m_owner] = 1'b0;
        e.busy  = !rq[m_owner];
        q.push_back(e);
    endtask

    task automatic model_edge();
        logic [3:0] r;
        logic [3:0] oth;
        r   = ~rq;
        oth = r;
        oth[m_owner] = 1'b0;
        if (!reset_) begin
            m_owner = 0;
            m_held  = 0;
        end else if (!r[m_owner]) begin
            m_owner = next_in_rotation(m_owner, oth);
            m_held  = 0;
        end else if (oth == 4'b0000) begin
            m_held = 0;
        end else begin
            m_held++;
`ifdef BUS_ARB_TIMEOUT_EN
            if (m_held == TO) begin
                m_owner = next_in_rotation(m_owner, oth);
                m_held  = 0;
            end
`endif
        end
        push_expect();
    endtask

    // One bus cycle: drive on the falling edge, model the rising edge.
    task automatic cycle(input logic [3:0] req_n, input logic rst_n);
        @(negedge clk);
        rq     = req_n;
        reset_ = rst_n;
        @(posedge clk);
        model_edge();
    endtask

    // n cycles with the given active-high request set, reset released.
    task automatic go(input logic [3:0] act, input int n);
        for (int i = 0; i < n; i++) cycle(~act, 1'b1);
    endtask

    // Drop reset between edges; outputs must return to owner 0 before the next edge.
    task automatic async_reset();
        @(negedge clk);
        #2;
        m_owner = 0;
        m_held  = 0;
        push_expect();
        reset_ = 1'b0;
        @(posedge clk);
        model_edge();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare DUT outputs against queued expectations.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge reset_);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("owner", 32'(owner), 32'(e.owner));
                chk("grants", 32'({m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_}), 32'(e.grnt));
                chk("bus_busy", 32'(bus_busy), 32'(e.busy));
                chk("one_grant_low",
                    32'($countones(~{m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_})), 32'd1);
            end
        end
    end

    // Stimulus.
    initial begin
        logic [3:0] act;
        // Reset with all masters idle.
        for (int i = 0; i < 3; i++) cycle(4'hF, 1'b0);
        // Simple handoff 0 -> 2.
        go(4'b0001, 3);
        go(4'b0101, 2);
        go(4'b0100, 2);
        go(4'b0000, 1);
        // Rotation fairness: 1 -> 2 -> 3 -> 0.
        go(4'b0010, 2);
        go(4'b1101, 1);
        go(4'b1001, 1);
        go(4'b0001, 1);
        go(4'b0000, 1);
        // Parking on 3, then hand to 1.
        go(4'b1000, 2);
        go(4'b0000, 10);
        go(4'b0010, 2);
        // Long contended hold by 0 against 1.
        go(4'b0001, 1);
        go(4'b0011, 1000);
        // Hold by 0 with 3 contending from the first cycle.
        go(4'b0000, 1);
        go(4'b0001, 3);
        go(4'b1001, 20);
        // Asynchronous reset in the middle of m2's ownership.
        go(4'b0100, 3);
        async_reset();
        for (int i = 0; i < 2; i++) cycle(~4'b0100, 1'b0);
        // Randomized sticky requests.
        act = 4'b0000;
        for (int i = 0; i < 2000; i++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 3) == 0) act[b] = ~act[b];
            end
            go(act, 1);
        end
        repeat (2) @(posedge clk);
        #2;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
